// File: rtl/uart_cmd_decoder_if.sv
// rtl/uart_cmd_decoder_if.sv - byte stream in / command strobe out bus for uart_cmd_decoder
// master drives received bytes and observes commands; slave is the decoder itself.
interface uart_cmd_decoder_if;
  logic [7:0] rx_data;
  logic       rx_done_tick;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic [7:0] cmd_arg;
  logic       chk_err;
  logic       timeout_err;
  logic [7:0] err_count;
  logic       busy;

  modport master (
    output rx_data, rx_done_tick,
    input  cmd_valid, cmd_code, cmd_arg, chk_err, timeout_err, err_count, busy
  );

  modport slave (
    input  rx_data, rx_done_tick,
    output cmd_valid, cmd_code, cmd_arg, chk_err, timeout_err, err_count, busy
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - frames sync/code/arg/checksum packets from the UART byte stream
// Emits a one-cycle command strobe with held data, checksum and inter-byte timeout errors.
module uart_cmd_decoder #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input logic               clk,
  input logic               rst,
  uart_cmd_decoder_if.slave bus
);

  localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    GET_CMD,
    GET_ARG,
    GET_CHK
  } state_t;

  state_t           state;
  logic [7:0]       code_q;
  logic [7:0]       arg_q;
  logic [CNT_W-1:0] tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      code_q          <= 8'h00;
      arg_q           <= 8'h00;
      tmo_cnt         <= '0;
      bus.cmd_valid   <= 1'b0;
      bus.cmd_code    <= 8'h00;
      bus.cmd_arg     <= 8'h00;
      bus.chk_err     <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.err_count   <= 8'h00;
      bus.busy        <= 1'b0;
    end else begin
      bus.cmd_valid   <= 1'b0;
      bus.chk_err     <= 1'b0;
      bus.timeout_err <= 1'b0;

      if (bus.rx_done_tick) begin
        // A byte always wins over an expiring timeout.
        tmo_cnt <= '0;
        case (state)
          IDLE: begin
            if (bus.rx_data == SYNC_BYTE) begin
              state    <= GET_CMD;
              bus.busy <= 1'b1;
            end
          end
          GET_CMD: begin
            code_q <= bus.rx_data;
            state  <= GET_ARG;
          end
          GET_ARG: begin
            arg_q <= bus.rx_data;
            state <= GET_CHK;
          end
          GET_CHK: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            if (bus.rx_data == (code_q ^ arg_q)) begin
              bus.cmd_code  <= code_q;
              bus.cmd_arg   <= arg_q;
              bus.cmd_valid <= 1'b1;
            end else begin
              bus.chk_err <= 1'b1;
              if (bus.err_count != 8'hFF) bus.err_count <= bus.err_count + 8'd1;
            end
          end
          default: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        endcase
      end else if (state != IDLE) begin
        if (tmo_cnt == TMO_LAST) begin
          state           <= IDLE;
          bus.busy        <= 1'b0;
          tmo_cnt         <= '0;
          bus.timeout_err <= 1'b1;
          if (bus.err_count != 8'hFF) bus.err_count <= bus.err_count + 8'd1;
        end else begin
          tmo_cnt <= tmo_cnt + CNT_ONE;
        end
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb/tb_uart_cmd_decoder.sv - randomized bench for uart_cmd_decoder against a packet-level model
// The model tracks the partial packet as a byte queue and idle time as elapsed cycles.
module tb_uart_cmd_decoder;

  localparam int         TMO  = 20;
  localparam logic [7:0] SYNC = 8'hA5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_cmd_decoder_if bus ();

  uart_cmd_decoder #(
    .SYNC_BYTE      (SYNC),
    .TIMEOUT_CYCLES (TMO)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] pkt[$];
  int         idle_cyc;
  logic [7:0] m_code, m_arg;
  int         m_errs;
  bit         m_valid, m_chk, m_tmo;

  int cyc;
  int obs_valid, obs_chk, obs_tmo;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pkt.delete();
    idle_cyc = 0;
    m_code   = 8'h00;
    m_arg    = 8'h00;
    m_errs   = 0;
    m_valid  = 1'b0;
    m_chk    = 1'b0;
    m_tmo    = 1'b0;
  endtask

  task automatic model_step(input bit tk, input logic [7:0] d);
    m_valid = 1'b0;
    m_chk   = 1'b0;
    m_tmo   = 1'b0;
    if (tk) begin
      idle_cyc = 0;
      if (pkt.size() != 0 || d == SYNC) pkt.push_back(d);
      if (pkt.size() == 4) begin
        if (pkt[3] == (pkt[1] ^ pkt[2])) begin
          m_code  = pkt[1];
          m_arg   = pkt[2];
          m_valid = 1'b1;
        end else begin
          m_chk  = 1'b1;
          m_errs = (m_errs < 255) ? m_errs + 1 : 255;
        end
        pkt.delete();
      end
    end else if (pkt.size() != 0) begin
      idle_cyc++;
      if (idle_cyc == TMO) begin
        m_tmo    = 1'b1;
        m_errs   = (m_errs < 255) ? m_errs + 1 : 255;
        idle_cyc = 0;
        pkt.delete();
      end
    end
  endtask

  task automatic check_all();
    check("cmd_valid",   bus.cmd_valid,   m_valid);
    check("cmd_code",    bus.cmd_code,    m_code);
    check("cmd_arg",     bus.cmd_arg,     m_arg);
    check("chk_err",     bus.chk_err,     m_chk);
    check("timeout_err", bus.timeout_err, m_tmo);
    check("err_count",   bus.err_count,   m_errs);
    check("busy",        bus.busy,        pkt.size() != 0);
    if (bus.cmd_valid === 1'b1)   obs_valid++;
    if (bus.chk_err === 1'b1)     obs_chk++;
    if (bus.timeout_err === 1'b1) obs_tmo++;
  endtask

  // Inputs change on the falling edge; outputs are compared on the next falling edge.
  task automatic cycle(input bit tk, input logic [7:0] d);
    bus.rx_done_tick = tk;
    bus.rx_data      = tk ? d : 8'($urandom);
    @(posedge clk);
    model_step(tk, d);
    @(negedge clk);
    cyc++;
    check_all();
    bus.rx_done_tick = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) cycle(1'b0, 8'h00);
    cycle(1'b1, b);
  endtask

  task automatic send_pkt(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k, input int gap);
    send(SYNC, gap);
    send(c, gap);
    send(a, gap);
    send(k, gap);
  endtask

  function automatic int rand_gap();
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(15, 24)) : int'($urandom_range(0, 4));
  endfunction

  initial begin
    int v0, c0, t0;
    logic [7:0] c, a;

    cyc = 0;
    obs_valid = 0;
    obs_chk = 0;
    obs_tmo = 0;
    bus.rx_data = 8'h00;
    bus.rx_done_tick = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;

    // Basic good packet
    v0 = obs_valid;
    send_pkt(8'h10, 8'h22, 8'h32, 7);
    cycle(1'b0, 8'h00);
    check("pkt1_valid_cnt", obs_valid - v0, 1);
    check("pkt1_code", bus.cmd_code, 8'h10);
    check("pkt1_arg", bus.cmd_arg, 8'h22);
    check("pkt1_busy", bus.busy, 1'b0);
    check("pkt1_errs", bus.err_count, 8'h00);

    // Bad checksum keeps previous command
    v0 = obs_valid; c0 = obs_chk;
    send_pkt(8'h07, 8'h01, 8'h05, 3);
    cycle(1'b0, 8'h00);
    check("bad_chk_cnt", obs_chk - c0, 1);
    check("bad_valid_cnt", obs_valid - v0, 0);
    check("bad_errs", bus.err_count, 8'h01);
    check("bad_code_held", bus.cmd_code, 8'h10);
    check("bad_arg_held", bus.cmd_arg, 8'h22);

    // Leading garbage is discarded silently
    v0 = obs_valid; c0 = obs_chk; t0 = obs_tmo;
    send(8'h00, 2); send(8'hFF, 2); send(8'h5A, 2);
    send_pkt(8'h01, 8'h02, 8'h03, 1);
    cycle(1'b0, 8'h00);
    check("garb_valid_cnt", obs_valid - v0, 1);
    check("garb_err_cnt", (obs_chk - c0) + (obs_tmo - t0), 0);
    check("garb_code", bus.cmd_code, 8'h01);
    check("garb_arg", bus.cmd_arg, 8'h02);

    // Timeout fires exactly TMO cycles after the last byte
    send(SYNC, 2);
    send(8'h01, 2);
    t0 = cyc;
    for (int i = 0; i < 2 * TMO && bus.timeout_err !== 1'b1; i++) cycle(1'b0, 8'h00);
    check("tmo_seen", bus.timeout_err, 1'b1);
    check("tmo_delay", cyc - t0, TMO);
    check("tmo_busy", bus.busy, 1'b0);
    check("tmo_errs", bus.err_count, 8'h02);
    v0 = obs_valid;
    send_pkt(8'h04, 8'h08, 8'h0C, 2);
    cycle(1'b0, 8'h00);
    check("after_tmo_valid", obs_valid - v0, 1);
    check("after_tmo_code", bus.cmd_code, 8'h04);

    // Byte landing in the expiry cycle wins
    v0 = obs_valid; t0 = obs_tmo;
    send(SYNC, 0);
    send(8'h33, TMO - 1);
    send(8'h44, TMO - 1);
    send(8'h77, TMO - 1);
    cycle(1'b0, 8'h00);
    check("expiry_no_tmo", obs_tmo - t0, 0);
    check("expiry_valid", obs_valid - v0, 1);
    check("expiry_code", bus.cmd_code, 8'h33);

    // Randomized mixed traffic
    for (int p = 0; p < 400; p++) begin
      c = 8'($urandom);
      a = 8'($urandom);
      case ($urandom_range(0, 9))
        0, 1:    send_pkt(c, a, c ^ a ^ 8'($urandom_range(1, 255)), rand_gap());
        2:       send(8'($urandom), rand_gap());
        3: begin send(SYNC, rand_gap()); send(c, rand_gap()); end
        default: send_pkt(c, a, c ^ a, rand_gap());
      endcase
    end

    // Saturation of the error counter
    for (int p = 0; p < 300; p++) begin
      c = 8'($urandom);
      a = 8'($urandom);
      send_pkt(c, a, c ^ a ^ 8'h5A, $urandom_range(0, 2));
    end
    cycle(1'b0, 8'h00);
    check("sat_errs", bus.err_count, 8'hFF);
    send_pkt(8'h01, 8'h01, 8'h01, 0);
    cycle(1'b0, 8'h00);
    check("sat_hold", bus.err_count, 8'hFF);

    // Asynchronous reset mid-packet
    send(SYNC, 1);
    send(8'h01, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_code", bus.cmd_code, 8'h00);
    check("rst_arg", bus.cmd_arg, 8'h00);
    check("rst_errs", bus.err_count, 8'h00);
    check("rst_valid", bus.cmd_valid, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    v0 = obs_valid;
    send(8'h02, 1);
    send(8'h03, 1);
    send_pkt(8'h10, 8'h22, 8'h32, 2);
    cycle(1'b0, 8'h00);
    check("post_rst_valid", obs_valid - v0, 1);
    check("post_rst_code", bus.cmd_code, 8'h10);
    check("post_rst_arg", bus.cmd_arg, 8'h22);
    check("post_rst_errs", bus.err_count, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
